plane_scheduler: RTL and testbench

PLANE_SCHEDULER -- requirements
Module: plane_scheduler

---
 rtl/plane_scheduler_pkg.sv | 21 ++
 rtl/plane_scheduler_if.sv | 40 ++++
 rtl/plane_pos_bank.sv | 54 +++++
 rtl/plane_scheduler.sv | 129 ++++++++++++
 tb/tb_plane_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/plane_scheduler_pkg.sv
// rtl/plane_scheduler_pkg.sv - shared types and constants for the plane scheduler
// Purpose: FSM state enum, default object count / coordinate width, color codes.
// Ports: none (package).
package plane_scheduler_pkg;

  localparam int NOBJ_DEFAULT = 4;
  localparam int CW_DEFAULT   = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] COLOR_TRANSPARENT = 3'd0;
  localparam logic [2:0] COLOR_GREY        = 3'd1;
  localparam logic [2:0] COLOR_WHITE       = 3'd2;
  localparam logic [2:0] COLOR_RED         = 3'd3;
  localparam logic [2:0] COLOR_BLACK       = 3'd4;

endpackage

// File: rtl/plane_scheduler_if.sv
// rtl/plane_scheduler_if.sv - pixel request/response and sprite lookup bundle
// Purpose: groups the request handshake, response handshake and shared lookup port.
// Ports (slave = scheduler side):
//   req_valid/req_ready/req_px/req_py        pixel request
//   rsp_valid/rsp_ready/rsp_color/rsp_obj/rsp_hit  pixel response
//   lk_ox/lk_oy/lk_px/lk_py out, lk_color in  combinational sprite lookup
interface plane_scheduler_if #(
  parameter int CW = plane_scheduler_pkg::CW_DEFAULT
) ();

  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_px;
  logic [CW-1:0] req_py;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [2:0]    rsp_color;
  logic [1:0]    rsp_obj;
  logic          rsp_hit;

  logic [CW-1:0] lk_ox;
  logic [CW-1:0] lk_oy;
  logic [CW-1:0] lk_px;
  logic [CW-1:0] lk_py;
  logic [2:0]    lk_color;

  modport master (
    output req_valid, req_px, req_py, rsp_ready, lk_color,
    input  req_ready, rsp_valid, rsp_color, rsp_obj, rsp_hit,
    input  lk_ox, lk_oy, lk_px, lk_py
  );

  modport slave (
    input  req_valid, req_px, req_py, rsp_ready, lk_color,
    output req_ready, rsp_valid, rsp_color, rsp_obj, rsp_hit,
    output lk_ox, lk_oy, lk_px, lk_py
  );

endinterface

// File: rtl/plane_pos_bank.sv
// rtl/plane_pos_bank.sv - double-banked object position storage
// Purpose: writes land in the shadow bank; commit copies shadow to active in one
//   cycle; reads come from the active bank only.
// Ports: clk, rst (async active-low), we/widx/wx/wy shadow write, commit,
//   ridx index -> rx/ry active position.
module plane_pos_bank #(
  parameter int NOBJ = 4,
  parameter int CW   = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    widx,
  input  logic [CW-1:0] wx,
  input  logic [CW-1:0] wy,
  input  logic          commit,
  input  logic [1:0]    ridx,
  output logic [CW-1:0] rx,
  output logic [CW-1:0] ry
);

  logic [CW-1:0] shadow_x [NOBJ];
  logic [CW-1:0] shadow_y [NOBJ];
  logic [CW-1:0] active_x [NOBJ];
  logic [CW-1:0] active_y [NOBJ];

  // Commit samples the shadow before this cycle's write lands, so a write in
  // the commit cycle only becomes visible at the following commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NOBJ; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        active_x[i] <= '0;
        active_y[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NOBJ; i++) begin
          active_x[i] <= shadow_x[i];
          active_y[i] <= shadow_y[i];
        end
      end
      if (we && (int'(widx) < NOBJ)) begin
        shadow_x[widx] <= wx;
        shadow_y[widx] <= wy;
      end
    end
  end

  assign rx = active_x[ridx];
  assign ry = active_y[ridx];

endmodule

// File: rtl/plane_scheduler.sv
// rtl/plane_scheduler.sv - per-pixel sprite priority scheduler
// Purpose: on each pixel request, walks objects 0..NOBJ-1 one per cycle through
//   the shared lookup and reports the first enabled opaque hit (lowest index wins).
// Ports: clk, rst (async active-low), frame_start (commit request),
//   pos_we/pos_idx/pos_x/pos_y (shadow position write), obj_en (live enables),
//   bus (plane_scheduler_if.slave: request, response, lookup).
module plane_scheduler
  import plane_scheduler_pkg::*;
#(
  parameter int NOBJ = NOBJ_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            pos_we,
  input  logic [1:0]      pos_idx,
  input  logic [CW-1:0]   pos_x,
  input  logic [CW-1:0]   pos_y,
  input  logic [NOBJ-1:0] obj_en,
  plane_scheduler_if.slave bus
);

  localparam logic [1:0] IDX_LAST = 2'(NOBJ - 1);

  state_t        state, state_d;
  logic [1:0]    idx, idx_d;
  logic [CW-1:0] px_l, px_d, py_l, py_d;
  logic [2:0]    color_q, color_d;
  logic [1:0]    obj_q, obj_d;
  logic          hit_q, hit_d;
  logic          commit_pending, pending_d;
  logic          commit;
  logic          hit;
  logic [CW-1:0] act_x, act_y;

  // A frame_start that arrives while idle commits in the same cycle; otherwise
  // it is held until the first idle cycle so the active bank is frozen mid-scan.
  assign commit    = (state == ST_IDLE) && (commit_pending || frame_start);
  assign pending_d = !commit && (commit_pending || frame_start);

  plane_pos_bank #(.NOBJ(NOBJ), .CW(CW)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (pos_we),
    .widx   (pos_idx),
    .wx     (pos_x),
    .wy     (pos_y),
    .commit (commit),
    .ridx   (idx),
    .rx     (act_x),
    .ry     (act_y)
  );

  assign hit = obj_en[idx] && (bus.lk_color != COLOR_TRANSPARENT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      px_l           <= '0;
      py_l           <= '0;
      color_q        <= '0;
      obj_q          <= '0;
      hit_q          <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      px_l           <= px_d;
      py_l           <= py_d;
      color_q        <= color_d;
      obj_q          <= obj_d;
      hit_q          <= hit_d;
      commit_pending <= pending_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    px_d    = px_l;
    py_d    = py_l;
    color_d = color_q;
    obj_d   = obj_q;
    hit_d   = hit_q;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          px_d    = bus.req_px;
          py_d    = bus.req_py;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          color_d = bus.lk_color;
          obj_d   = idx;
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else if (idx == IDX_LAST) begin
          color_d = COLOR_TRANSPARENT;
          obj_d   = '0;
          hit_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is held low while reset is asserted so every output reads zero.
  assign bus.req_ready = rst && (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_color = color_q;
  assign bus.rsp_obj   = obj_q;
  assign bus.rsp_hit   = hit_q;
  assign bus.lk_ox     = (state == ST_SCAN) ? act_x : '0;
  assign bus.lk_oy     = (state == ST_SCAN) ? act_y : '0;
  assign bus.lk_px     = (state == ST_SCAN) ? px_l  : '0;
  assign bus.lk_py     = (state == ST_SCAN) ? py_l  : '0;

endmodule

// File: tb/tb_plane_scheduler.sv
// tb/tb_plane_scheduler.sv - self-checking bench for plane_scheduler
module tb_plane_scheduler;
  import plane_scheduler_pkg::*;

  localparam int NOBJ = 4;
  localparam int CW   = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic            pos_we;
  logic [1:0]      pos_idx;
  logic [CW-1:0]   pos_x, pos_y;
  logic [NOBJ-1:0] obj_en;

  plane_scheduler_if #(.CW(CW)) bus ();

  plane_scheduler #(.NOBJ(NOBJ), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pos_we      (pos_we),
    .pos_idx     (pos_idx),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .obj_en      (obj_en),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Sprite lookup model: 16x16 box anchored at (ox,oy); fixed fill color or a
  // diagonal pattern in which some pixels are transparent.
  logic [2:0] fill;

  function automatic logic [2:0] look(input logic [CW-1:0] ox, input logic [CW-1:0] oy,
                                      input logic [CW-1:0] px, input logic [CW-1:0] py);
    logic [CW-1:0] dx, dy;
    dx = px - ox;
    dy = py - oy;
    if (dx < 16 && dy < 16) begin
      if (fill != COLOR_TRANSPARENT) return fill;
      return 3'((dx + dy) % 11'd5);
    end
    return COLOR_TRANSPARENT;
  endfunction

  assign bus.lk_color = look(bus.lk_ox, bus.lk_oy, bus.lk_px, bus.lk_py);

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [CW-1:0] sh_x [NOBJ], sh_y [NOBJ], ac_x [NOBJ], ac_y [NOBJ];
  bit            m_pend, m_idle;
  int            cyc, first_v;
  logic [CW-1:0] seen_ox [16], seen_oy [16];
  logic [2:0]    exp_color, got_color;
  logic [1:0]    exp_obj, got_obj;
  logic          exp_hit, got_hit;
  int            exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NOBJ; i++) begin
      sh_x[i] = '0; sh_y[i] = '0; ac_x[i] = '0; ac_y[i] = '0;
    end
    m_pend = 0;
    m_idle = 1;
  endtask

  task automatic predict(input logic [CW-1:0] px, input logic [CW-1:0] py);
    bit found;
    found = 0;
    exp_hit = 0; exp_obj = 0; exp_color = 0; exp_lat = NOBJ + 1;
    for (int k = 0; k < NOBJ; k++) begin
      if (!found && obj_en[k] && look(ac_x[k], ac_y[k], px, py) != 0) begin
        found     = 1;
        exp_hit   = 1;
        exp_obj   = 2'(k);
        exp_color = look(ac_x[k], ac_y[k], px, py);
        exp_lat   = 2 + k;
      end
    end
  endtask

  // One clock: update the model from the inputs driven this cycle, clock, then
  // sample #1 after the edge and drop one-cycle pulses.
  task automatic step();
    bit acc, done;
    acc  = m_idle && bus.req_valid;
    done = !m_idle && bus.rsp_valid && bus.rsp_ready;
    if (m_idle && (m_pend || frame_start)) begin
      for (int i = 0; i < NOBJ; i++) begin ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; end
      m_pend = 0;
    end else if (frame_start) begin
      m_pend = 1;
    end
    if (pos_we && int'(pos_idx) < NOBJ) begin
      sh_x[pos_idx] = pos_x;
      sh_y[pos_idx] = pos_y;
    end
    if (acc) predict(bus.req_px, bus.req_py);
    @(posedge clk);
    #1;
    pos_we = 0;
    frame_start = 0;
    if (acc) begin m_idle = 0; cyc = 1; bus.req_valid = 0; end
    else cyc++;
    if (done) begin m_idle = 1; bus.rsp_ready = 0; end
    if (cyc < 16) begin seen_ox[cyc] = bus.lk_ox; seen_oy[cyc] = bus.lk_oy; end
    if (!m_idle && bus.rsp_valid && first_v == 0) first_v = cyc;
  endtask

  task automatic write_pos(input int i, input int x, input int y, input bit fs);
    pos_we = 1; pos_idx = 2'(i); pos_x = CW'(x); pos_y = CW'(y); frame_start = fs;
    step();
  endtask

  task automatic issue_req(input int px, input int py);
    bus.req_valid = 1; bus.req_px = CW'(px); bus.req_py = CW'(py);
    first_v = 0;
    for (int i = 0; i < 16; i++) begin seen_ox[i] = '0; seen_oy[i] = '0; end
    step();
  endtask

  task automatic finish_req(input int stall);
    int n;
    n = 0;
    if (!bus.rsp_valid) chk("req_ready_scan", bus.req_ready, 0);
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("latency", first_v, exp_lat);
    chk("rsp_color", bus.rsp_color, exp_color);
    chk("rsp_obj", bus.rsp_obj, exp_obj);
    chk("rsp_hit", bus.rsp_hit, exp_hit);
    got_color = bus.rsp_color; got_obj = bus.rsp_obj; got_hit = bus.rsp_hit;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_color", bus.rsp_color, exp_color);
      chk("stall_obj", bus.rsp_obj, exp_obj);
      chk("stall_hit", bus.rsp_hit, exp_hit);
      chk("stall_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1;
    step();
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  task automatic request(input int px, input int py, input int stall);
    issue_req(px, py);
    finish_req(stall);
  endtask

  initial begin
    rst = 0; frame_start = 0; pos_we = 0; pos_idx = 0; pos_x = 0; pos_y = 0;
    obj_en = 0; fill = 0; cyc = 0; first_v = 0;
    bus.req_valid = 0; bus.req_px = 0; bus.req_py = 0; bus.rsp_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_color", bus.rsp_color, 0);
    rst = 1;
    step();
    chk("first_req_ready", bus.req_ready, 1);
    chk("idle_lk_ox", bus.lk_ox, 0);

    // Single opaque hit on object 0
    write_pos(0, 100, 100, 0);
    frame_start = 1; step();
    fill = COLOR_RED; obj_en = 4'b1111;
    request(110, 105, 0);
    chk("d032_color", got_color, 3);
    chk("d032_obj", got_obj, 0);
    chk("d032_hit", got_hit, 1);
    chk("d032_lat", first_v, 2);

    // Priority with disabled objects, and full miss
    write_pos(1, 100, 100, 0);
    write_pos(2, 100, 100, 0);
    write_pos(3, 100, 100, 1);
    obj_en = 4'b1010;
    request(110, 105, 0);
    chk("d033_obj", got_obj, 1);
    obj_en = 4'b0000;
    request(110, 105, 0);
    chk("d033_miss_hit", got_hit, 0);
    chk("d033_miss_color", got_color, 0);
    chk("d033_miss_lat", first_v, 5);

    // Write and commit in the same idle cycle
    write_pos(2, 300, 300, 1);
    request(0, 0, 0);
    chk("d037_old", seen_ox[3], 100);
    frame_start = 1; step();
    request(0, 0, 0);
    chk("d037_new", seen_ox[3], 300);

    // Write and frame_start while scanning
    issue_req(0, 0);
    write_pos(1, 200, 50, 0);
    frame_start = 1; step();
    finish_req(0);
    chk("d034_frozen_ox", seen_ox[2], 100);
    request(0, 0, 0);
    chk("d034_new_ox", seen_ox[2], 200);
    chk("d034_new_oy", seen_oy[2], 50);

    // Back-pressure on the response
    write_pos(1, 100, 100, 1);
    obj_en = 4'b1111;
    request(110, 105, 10);

    // Reset mid-scan
    obj_en = 4'b0000;
    issue_req(0, 0);
    step();
    rst = 0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_lk_ox", bus.lk_ox, 0);
    chk("rst_lk_px", bus.lk_px, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_hit", bus.rsp_hit, 0);
    model_reset();
    bus.req_valid = 0; bus.rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    step();
    chk("after_rst_req_ready", bus.req_ready, 1);
    chk("after_rst_rsp_valid", bus.rsp_valid, 0);
    fill = COLOR_RED; obj_en = 4'b0001;
    request(5, 5, 0);
    chk("after_rst_hit", got_hit, 1);

    // Randomized traffic against the model
    fill = COLOR_TRANSPARENT;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NOBJ; i++)
        if ($urandom_range(1) == 1) write_pos(i, $urandom_range(47), $urandom_range(47), 0);
      if ($urandom_range(1) == 1) begin frame_start = 1; step(); end
      obj_en = 4'($urandom_range(15));
      issue_req($urandom_range(63), $urandom_range(63));
      if ($urandom_range(1) == 1) begin
        pos_we = 1; pos_idx = 2'($urandom_range(3));
        pos_x = CW'($urandom_range(47)); pos_y = CW'($urandom_range(47));
        frame_start = 1'($urandom_range(1));
        step();
      end
      finish_req($urandom_range(2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
